// File: rtl/ingress_dwrr_arb_pkg.sv
// Shared switch definitions for the ingress deficit-round-robin arbiter.
// Holds the arbiter state encoding and the default geometry: number of
// ingress ports, frame-length width, deficit-counter width and the minimum
// effective quantum.
package ingress_dwrr_arb_pkg;

  localparam int unsigned NPORT = 4;
  localparam int unsigned LEN_W = 11;
  localparam int unsigned DEF_W = 12;
  localparam int unsigned QMIN  = 64;

  typedef enum logic [0:0] {
    StScan,
    StGrant
  } arb_state_e;

endpackage

// File: rtl/ingress_dwrr_arb.sv
// Ingress deficit-round-robin arbiter.
// Chooses which ingress pointer FIFO may move its head frame into the shared
// FIFO. Each port earns max(quantum, QMIN) bytes of credit per visit and is
// granted whenever its credit covers the head frame length.
//
// Ports:
//   clk, rstn      clock; asynchronous active-low reset
//   req            per-port "pointer FIFO not empty"
//   req_len        per-port head-frame length, LEN_W bits per port
//   quantum        per-port quantum in bytes, LEN_W bits per port
//   port_en        per-port enable; a disabled port looks like req=0
//   bp             shared-FIFO backpressure; blocks new grants
//   grant_vld      a frame transfer is granted
//   grant_port     index of the granted port
//   grant_len      frame length latched at grant
//   done           datapath pulse: granted frame fully moved
//   err_done       sticky: done seen outside the grant state
module ingress_dwrr_arb #(
  parameter int unsigned NPORT = ingress_dwrr_arb_pkg::NPORT,
  parameter int unsigned LEN_W = ingress_dwrr_arb_pkg::LEN_W,
  parameter int unsigned DEF_W = ingress_dwrr_arb_pkg::DEF_W,
  parameter int unsigned QMIN  = ingress_dwrr_arb_pkg::QMIN
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT*LEN_W-1:0] req_len,
  input  logic [NPORT*LEN_W-1:0] quantum,
  input  logic [NPORT-1:0]       port_en,
  input  logic                   bp,
  output logic                   grant_vld,
  output logic [1:0]             grant_port,
  output logic [LEN_W-1:0]       grant_len,
  input  logic                   done,
  output logic                   err_done
);
  import ingress_dwrr_arb_pkg::*;

  arb_state_e state_q;
  logic [1:0] ptr_q;
  logic       fresh_q;

  logic [NPORT-1:0][DEF_W-1:0] deficit;
  logic [NPORT-1:0][LEN_W-1:0] len_arr;

  logic             req_hit;
  logic [DEF_W-1:0] cur_def;
  logic [LEN_W-1:0] cur_len;
  logic             scan_go;
  logic             do_clear;
  logic             do_add;
  logic             do_sub;
  logic             do_adv;

  // Decision for the port under the pointer; at most one action is true.
  always_comb begin
    cur_def  = deficit[ptr_q];
    cur_len  = len_arr[ptr_q];
    req_hit  = req[ptr_q] & port_en[ptr_q];
    scan_go  = (state_q == StScan) & ~bp;
    do_clear = scan_go & ~req_hit;
    do_add   = scan_go & req_hit & fresh_q;
    do_sub   = scan_go & req_hit & ~fresh_q & (cur_def >= DEF_W'(cur_len));
    do_adv   = scan_go & req_hit & ~fresh_q & ~(cur_def >= DEF_W'(cur_len));
  end

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    logic [LEN_W-1:0] q_raw;
    logic [LEN_W-1:0] q_eff;
    logic [DEF_W:0]   sum;
    logic [DEF_W-1:0] def_q;
    logic [DEF_W-1:0] def_d;
    logic             sel;

    assign len_arr[i] = req_len[i*LEN_W +: LEN_W];
    assign q_raw      = quantum[i*LEN_W +: LEN_W];
    assign q_eff      = (q_raw < LEN_W'(QMIN)) ? LEN_W'(QMIN) : q_raw;
    // One extra bit catches overflow for saturation.
    assign sum        = {1'b0, def_q} + (DEF_W + 1)'(q_eff);
    assign sel        = (ptr_q == 2'(i));

    always_comb begin
      def_d = def_q;
      if (sel) begin
        if (do_clear) begin
          def_d = '0;
        end else if (do_add) begin
          def_d = sum[DEF_W] ? '1 : sum[DEF_W-1:0];
        end else if (do_sub) begin
          def_d = def_q - DEF_W'(cur_len);
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        def_q <= '0;
      end else begin
        def_q <= def_d;
      end
    end

    assign deficit[i] = def_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StScan;
      ptr_q      <= '0;
      fresh_q    <= 1'b1;
      grant_vld  <= 1'b0;
      grant_port <= '0;
      grant_len  <= '0;
      err_done   <= 1'b0;
    end else begin
      // Includes done arriving on the same edge that enters the grant state.
      if (done && (state_q != StGrant)) begin
        err_done <= 1'b1;
      end
      unique case (state_q)
        StScan: begin
          if (do_clear || do_adv) begin
            ptr_q   <= ptr_q + 2'd1;
            fresh_q <= 1'b1;
          end else if (do_add) begin
            fresh_q <= 1'b0;
          end else if (do_sub) begin
            grant_len  <= cur_len;
            grant_port <= ptr_q;
            grant_vld  <= 1'b1;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          // Pointer stays put so the same port keeps going while credit lasts.
          if (done) begin
            grant_vld <= 1'b0;
            fresh_q   <= 1'b0;
            state_q   <= StScan;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

endmodule
